// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill controller and its victim selector.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_FILL  = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } refill_state_e;

    localparam int WORD_SEL_LSB = 2;
    localparam int OFFSET_W     = 4;

    localparam logic [1:0] MODE_1WAY = 2'b00;
    localparam logic [1:0] MODE_2WAY = 2'b01;
    localparam logic [1:0] MODE_4WAY = 2'b10;
    localparam logic [1:0] MODE_8WAY = 2'b11;

    // Number of ways selectable in a given associativity mode.
    function automatic logic [3:0] ways_of(input logic [1:0] mode);
        logic [3:0] ways;
        case (mode)
            MODE_1WAY: ways = 4'd1;
            MODE_2WAY: ways = 4'd2;
            MODE_4WAY: ways = 4'd4;
            MODE_8WAY: ways = 4'd8;
            default:   ways = 4'd1;
        endcase
        return ways;
    endfunction

endpackage

// File: rtl/cache_victim_rr.sv
// Round-robin victim way counter; the count wraps within the ways of the current mode.
module cache_victim_rr
    import cache_pkg::*;
#(
    parameter int MAX_WAYS = 8,
    parameter int WAY_W    = $clog2(MAX_WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [1:0]       mode,
    output logic [WAY_W-1:0] mask,
    output logic [WAY_W-1:0] way
);

    logic [WAY_W-1:0] count_r;

    // Mask of valid way bits for the mode, and the masked victim.
    always_comb begin
        mask = WAY_W'(ways_of(mode) - 4'd1);
        way  = count_r & mask;
    end

    // Victim counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= '0;
        end else if (advance) begin
            count_r <= (count_r + {{(WAY_W-1){1'b0}}, 1'b1}) & mask;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: bursts a 4-word line, streams it into the cache, replays a store.
// Optional build macro CRITICAL_WORD_FIRST_EN: burst starts at the faulting word, first beat flagged.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int MAX_WAYS       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        selection_signal,
    output logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [2:0]        fill_way,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_done
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic              fill_critical
`endif
);

    localparam int         WAY_W    = $clog2(MAX_WAYS);
    localparam logic [1:0] LAST_CNT = 2'(WORDS_PER_LINE - 1);

    refill_state_e                  state_r;
    refill_state_e                  next_state_s;
    logic [ADDR_W-1:WORD_SEL_LSB]   addr_r;
    logic                           write_r;
    logic [DATA_W-1:0]              data_r;
    logic [1:0]                     mode_r;
    logic [1:0]                     beat_r;
    logic [1:0]                     cnt_r;
    logic                           last_r;
    logic [1:0]                     start_beat_s;
    logic [ADDR_W-1:0]              req_addr_s;
    logic [1:0]                     victim_mode_s;
    logic                           victim_adv_s;
    logic [WAY_W-1:0]               victim_mask_s;
    logic [WAY_W-1:0]               victim_way_s;
    logic                           capture_s;
    logic                           unused_s;

    assign unused_s = ^{address[WORD_SEL_LSB-1:0], victim_mask_s};

    // Burst start word and request address for the incoming miss.
    always_comb begin
`ifdef CRITICAL_WORD_FIRST_EN
        start_beat_s = address[OFFSET_W-1:WORD_SEL_LSB];
        req_addr_s   = {address[ADDR_W-1:WORD_SEL_LSB], {WORD_SEL_LSB{1'b0}}};
`else
        start_beat_s = 2'b00;
        req_addr_s   = {address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
`endif
    end

    // Victim selector sees the live mode only while idle, so a mid-refill mode change is ignored.
    always_comb begin
        if (state_r == ST_IDLE) begin
            victim_mode_s = selection_signal;
        end else begin
            victim_mode_s = mode_r;
        end
        victim_adv_s = (state_r == ST_DONE);
        capture_s    = (state_r == ST_FILL) && !last_r && mem_rvalid;
    end

    cache_victim_rr #(
        .MAX_WAYS (MAX_WAYS),
        .WAY_W    (WAY_W)
    ) u_victim (
        .clk     (clk),
        .reset   (reset),
        .advance (victim_adv_s),
        .mode    (victim_mode_s),
        .mask    (victim_mask_s),
        .way     (victim_way_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; FILL lingers one cycle after the last beat so its fill write lands first.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (miss) next_state_s = ST_REQ;
                else      next_state_s = ST_IDLE;
            end
            ST_REQ: begin
                if (mem_ack) next_state_s = ST_FILL;
                else         next_state_s = ST_REQ;
            end
            ST_FILL: begin
                if (last_r && write_r) next_state_s = ST_STORE;
                else if (last_r)       next_state_s = ST_DONE;
                else                   next_state_s = ST_FILL;
            end
            ST_STORE: next_state_s = ST_DONE;
            ST_DONE:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Latched miss context, beat tracking and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_r     <= '0;
            write_r    <= 1'b0;
            data_r     <= '0;
            mode_r     <= 2'b00;
            beat_r     <= 2'b00;
            cnt_r      <= 2'b00;
            last_r     <= 1'b0;
            busy       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            fill_way   <= 3'b000;
            fill_data  <= '0;
            fill_done  <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
            fill_critical <= 1'b0;
`endif
        end else begin
            busy       <= (next_state_s != ST_IDLE);
            mem_rd     <= (next_state_s == ST_REQ);
            fill_done  <= (next_state_s == ST_DONE);
            fill_valid <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
            fill_critical <= 1'b0;
`endif
            if ((state_r == ST_IDLE) && miss) begin
                addr_r   <= address[ADDR_W-1:WORD_SEL_LSB];
                write_r  <= write;
                data_r   <= data_in;
                mode_r   <= selection_signal;
                mem_addr <= req_addr_s;
                fill_way <= 3'(victim_way_s);
                beat_r   <= start_beat_s;
                cnt_r    <= 2'b00;
                last_r   <= 1'b0;
            end
            if (capture_s) begin
                fill_valid <= 1'b1;
                fill_data  <= mem_rdata;
                fill_addr  <= {addr_r[ADDR_W-1:OFFSET_W], beat_r, {WORD_SEL_LSB{1'b0}}};
                beat_r     <= beat_r + 2'd1;
                cnt_r      <= cnt_r + 2'd1;
                last_r     <= (cnt_r == LAST_CNT);
`ifdef CRITICAL_WORD_FIRST_EN
                fill_critical <= (cnt_r == 2'b00);
`endif
            end else if (next_state_s == ST_STORE) begin
                // Replay the pending store over the word just filled from memory.
                fill_valid <= 1'b1;
                fill_data  <= data_r;
                fill_addr  <= {addr_r, {WORD_SEL_LSB{1'b0}}};
            end
        end
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-handling stage directly downstream of cache_memory. Consumes its `miss` flag and the faulting address, bursts the 16-byte line from backing memory, and streams the words back into the cache data arrays. Picks the victim way for the current associativity mode (`selection_signal`). Replays a pending write-miss store once the fill completes.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
WORDS_PER_LINE, 4, words per line (offset field 4 bits, word index = address[3:2])
MAX_WAYS, 8, ways in 8-way mode (selection_signal 2'b11)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
miss  in  1  cache miss flag from cache_memory
address  in  ADDR_W  faulting byte address
write  in  1  faulting access is a store
data_in  in  DATA_W  store data of faulting access
selection_signal  in  2  associativity mode: 00=1-way, 01=2-way, 10=4-way, 11=8-way
busy  out  1  controller owns the cache; stall the requester
mem_rd  out  1  burst read request to backing memory
mem_addr  out  ADDR_W  burst start address (word aligned)
mem_ack  in  1  backing memory accepted the request
mem_rvalid  in  1  one returned word valid this cycle
mem_rdata  in  DATA_W  returned word
fill_valid  out  1  write fill_data into the cache this cycle
fill_addr  out  ADDR_W  target byte address of the fill word
fill_way  out  3  victim way
fill_data  out  DATA_W  word to write
fill_done  out  1  one-cycle pulse: line installed, tag/valid may be set

Behaviour:
- Interface: one clock `clk`. `reset` is synchronous and active-low. While reset=0 at a posedge: state=IDLE, beat counter=0, victim counter=0, and every output =0.
- Reset mid-operation aborts the refill. mem_rd and fill_valid drop at that edge. Partially filled words are not invalidated here, because the tag is never committed without fill_done.
- FSM states: IDLE, REQ, FILL, STORE, DONE.
- IDLE: busy=0. When miss=1 at a posedge, latch address, write, data_in and selection_signal, then go to REQ. busy=1 from the next cycle.
- REQ: mem_rd=1 and mem_addr={address[31:4],4'b0}. Both are held until mem_ack=1, which moves the FSM to FILL and drops mem_rd at that edge. mem_ack=0 stalls the FSM indefinitely.
- FILL: each mem_rvalid=1 cycle registers one beat. The following cycle gives fill_valid=1, fill_data=mem_rdata, fill_addr={line,beat[1:0],2'b00}. The beat counter is 2 bits and wraps modulo 4. mem_rvalid=0 cycles insert bubbles with no timeout. On the 4th beat, go to STORE if the latched write=1, otherwise go to DONE.
- STORE: one cycle with fill_valid=1, fill_data=latched data_in, and fill_addr=latched word address. This overwrites the freshly filled word.
- DONE: fill_done=1 for exactly one cycle. The victim counter then advances modulo ways(mode), where ways = 1, 2, 4, 8 for mode 00..11. Next state is IDLE.
- fill_way: latched victim counter ANDed with (ways-1). It is stable from REQ through DONE. Mode 00 therefore always gives way 0.
- A mode change mid-refill has no effect until the next miss.
- miss is ignored in every state except IDLE.
- mem_rvalid outside FILL is ignored.
- miss and a back-to-back new miss in the cycle after DONE are accepted, giving at least 1 idle cycle between refills.
- Minimum latency from miss to fill_done with immediate ack and continuous rvalid: 7 cycles for a read miss, 8 for a write miss.

Optional Feature:
CRITICAL_WORD_FIRST_EN.
- Defined: mem_addr = the faulting word address. The beat counter starts at address[3:2] and wraps, e.g. 1,2,3,0. Beat 0 of the burst is additionally flagged so the cache can forward it.
- Undefined: the burst always starts at word 0, as described above.

Decomposition:
- Shared package cache_pkg holds:
  - state encoding enum;
  - WORD_SEL_LSB=2 and OFFSET_W=4;
  - the mode constants MODE_1WAY..MODE_8WAY;
  - function ways_of(mode).
- One sub-module, cache_victim_rr: a round-robin victim counter with advance and mode inputs, plus mask output.

Test Plan:
- Read miss, mode 00, address 0x700000C0, immediate ack, rdata 0xA0..0xA3 → fill_addr 0x700000C0/C4/C8/CC, fill_way=0, fill_done at cycle 7, busy back to 0 the next cycle.
- Write miss, address 164 (0xA4), data_in=2 → 4 fills plus a STORE writing 2 at 0xA4, then fill_done.
- Mode 11, five consecutive misses → fill_way 0,1,2,3,4. Switch to mode 01, next miss → way masked to 1.
- mem_ack delayed 5 cycles and rvalid gaps between beats → mem_rd held high, 4 fills in order, no extra beats.
- Reset asserted (0) during FILL after 2 beats → next edge: all outputs 0, IDLE. A subsequent miss at 0x100000D0 refills correctly from word 0.
- CRITICAL_WORD_FIRST_EN defined, miss at 0x500000D8 → mem_addr 0x500000D8, fill order D8, DC, D0, D4.
